// File: rtl/des_pkg.sv
// Shared DES key-schedule types and tables: PC1/PC2 permutation indices (0-based,
// bit 0 = DES bit 1) and the per-round left-shift schedule.
package des_pkg;

  localparam int unsigned NROUNDS = 16;
  localparam int unsigned HALF_W  = 28;
  localparam int unsigned RKEY_W  = 48;

  typedef logic [0:HALF_W-1] half_t;
  typedef logic [0:RKEY_W-1] rkey_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned PC1_TAB [56] = '{
    56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
     9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
    62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
    13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
  };

  localparam int unsigned PC2_TAB [48] = '{
    13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
    22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
    40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
    43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
  };

  // Bit r set means round r+1 rotates by two; clear means by one.
  localparam logic [0:NROUNDS-1] SHIFT_TWO = 16'b0011_1111_0111_1110;

endpackage

// File: rtl/des_key_perm.sv
// Combinational DES key permutations: PC1 (64->56) of the user key and PC2 (56->48)
// of the current C/D pair.
module des_key_perm
  import des_pkg::*;
(
  input  logic [0:63] key,
  input  logic [0:55] cd,
  output logic [0:55] pc1,
  output rkey_t       rkey
);

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[i] = key[6'(PC1_TAB[i])];
  end

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign rkey[j] = cd[6'(PC2_TAB[j])];
  end

  // Parity bits and the eight C/D bits PC2 discards are intentionally dropped.
  logic unused_parity_c;
  logic unused_cd_c;
  assign unused_parity_c = ^{key[7], key[15], key[23], key[31],
                             key[39], key[47], key[55], key[63]};
  assign unused_cd_c     = ^{cd[8], cd[17], cd[21], cd[24],
                             cd[34], cd[37], cd[42], cd[53]};

endmodule

// File: rtl/roundkey_seq.sv
// Iterative DES key scheduler: emits the 16 round keys one per valid/ready handshake,
// forward (K1..K16) or reverse (K16..K1) by rotating the C/D halves left or right.
module roundkey_seq
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] user_key,
  input  logic        clear,
  input  logic        key_ready,
  output rkey_t       key_out,
  output logic        key_valid,
  output logic [3:0]  key_round,
  output logic        busy,
  output logic        done
);

  state_t      state;
  half_t       c_q, d_q;
  logic        decrypt_q;
  logic [0:55] pc1_c;
  logic        last_c;
  logic        two_c;

  des_key_perm u_perm (
    .key  (user_key),
    .cd   ({c_q, d_q}),
    .pc1  (pc1_c),
    .rkey (key_out)
  );

  function automatic half_t rot(input half_t h, input logic right, input logic two);
    case ({right, two})
      2'b00:   return {h[1:27], h[0]};
      2'b01:   return {h[2:27], h[0:1]};
      2'b10:   return {h[27], h[0:26]};
      default: return {h[26:27], h[0:25]};
    endcase
  endfunction

  // Forward steps use the next round's shift; reverse undoes the current round's.
  always_comb begin
    last_c = decrypt_q ? (key_round == 4'd0) : (key_round == 4'(NROUNDS - 1));
    two_c  = decrypt_q ? SHIFT_TWO[key_round] : SHIFT_TWO[4'(key_round + 4'd1)];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      decrypt_q <= 1'b0;
      key_valid <= 1'b0;
      key_round <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      decrypt_q <= 1'b0;
      key_valid <= 1'b0;
      key_round <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            decrypt_q <= decrypt;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
            if (decrypt) begin
              c_q       <= pc1_c[0:27];
              d_q       <= pc1_c[28:55];
              key_round <= 4'(NROUNDS - 1);
            end else begin
              c_q       <= rot(pc1_c[0:27], 1'b0, 1'b0);
              d_q       <= rot(pc1_c[28:55], 1'b0, 1'b0);
              key_round <= 4'd0;
            end
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (last_c) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              c_q       <= rot(c_q, decrypt_q, two_c);
              d_q       <= rot(d_q, decrypt_q, two_c);
              key_round <= decrypt_q ? 4'(key_round - 4'd1) : 4'(key_round + 4'd1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roundkey_seq.sv
// Self-checking bench for roundkey_seq against a cumulative-rotation DES key schedule model.
module tb_roundkey_seq;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        decrypt;
  logic [0:63] user_key;
  logic        clear;
  logic        key_ready;
  logic [0:47] key_out;
  logic        key_valid;
  logic [3:0]  key_round;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] got [16];

  roundkey_seq dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .decrypt   (decrypt),
    .user_key  (user_key),
    .clear     (clear),
    .key_ready (key_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_round (key_round),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Standard DES tables, 1-based bit numbers with bit 1 = MSB.
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Round key r (0-based): each half rotated left by the running shift total.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [55:0] cc;
    logic [27:0] c, d;
    logic [47:0] o;
    int tot = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    for (int i = 0; i <= r; i++) tot += shifts[i];
    cc = {cd[55:28], cd[55:28]} << tot;
    c  = cc[55:28];
    cc = {cd[27:0], cd[27:0]} << tot;
    d  = cc[55:28];
    cd = {c, d};
    for (int j = 0; j < 48; j++) o[47-j] = cd[56-pc2_t[j]];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(key_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_key"},   64'(key_out),   64'd0);
    chk({tag, "_round"}, 64'(key_round), 64'd0);
  endtask

  // Runs one full schedule; inj >= 0 fires an illegal start at that key position.
  task automatic run_seq(input logic [63:0] k, input logic dec, input bit bp, input int inj);
    int idx = 0;
    int cyc = 0;
    int r;
    bit injected = 0;
    user_key = k; decrypt = dec; start = 1'b1; key_ready = 1'b0;
    step();
    start = 1'b0;
    chk("valid_after_start", 64'(key_valid), 64'd1);
    chk("busy_after_start",  64'(busy),      64'd1);
    while (idx < 16 && cyc < 200) begin
      r = dec ? 15 - idx : idx;
      chk("key_out", 64'(key_out), 64'(ref_key(k, r)));
      chk("key_round", 64'(key_round), 64'(r));
      chk("busy_mid", 64'(busy), 64'd1);
      got[idx] = key_out;
      key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == inj && !injected) begin
        start = 1'b1; user_key = ~k; decrypt = ~dec; injected = 1;
      end
      step();
      start = 1'b0;
      if (key_ready) idx++;
      cyc++;
    end
    chk("accept_count", 64'(idx), 64'd16);
    if (!bp) chk("cycles_per_key", 64'(cyc), 64'd16);
    key_ready = 1'b0;
    chk("done_pulse", 64'(done),      64'd1);
    chk("done_busy",  64'(busy),      64'd0);
    chk("done_valid", 64'(key_valid), 64'd0);
    start = 1'b1; user_key = ~k; decrypt = ~dec;
    step();
    start = 1'b0;
    chk("done_single", 64'(done),      64'd0);
    chk("start_in_done_ignored", 64'(key_valid), 64'd0);
    step();
    chk("stay_idle", 64'(key_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] kk;
    n_rst = 1'b0; start = 1'b0; decrypt = 1'b0; user_key = '0; clear = 1'b0; key_ready = 1'b0;
    step();
    chk_idle("reset");
    n_rst = 1'b1;
    step();
    chk_idle("post_reset");

    kk = 64'h736865726c6f636b;
    run_seq(kk, 1'b0, 1'b0, -1);
    chk("vec_fwd_k1",  64'(got[0]),  64'h0000e0be66ce0b2b);
    chk("vec_fwd_k2",  64'(got[1]),  64'h0000e0b67635c5a2);
    chk("vec_fwd_k16", 64'(got[15]), 64'h0000f0be262bf356);

    run_seq(kk, 1'b1, 1'b0, -1);
    chk("vec_rev_first",  64'(got[0]),  64'h0000f0be262bf356);
    chk("vec_rev_second", 64'(got[1]),  64'h0000f0be26f314a3);
    chk("vec_rev_last",   64'(got[15]), 64'h0000e0be66ce0b2b);

    // Random keys, random mode, random backpressure.
    for (int t = 0; t < 4; t++) begin
      kk = {$urandom, $urandom};
      run_seq(kk, 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    // Start mid-stream must not disturb the running schedule.
    run_seq(64'h736865726c6f636b, 1'b0, 1'b0, 5);
    kk = {$urandom, $urandom};
    run_seq(kk, 1'b1, 1'b1, 5);

    // Clear at round 8.
    kk = {$urandom, $urandom};
    user_key = kk; decrypt = 1'b0; start = 1'b1; key_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && key_round != 4'd8; i++) step();
    chk("clear_at_round", 64'(key_round), 64'd8);
    clear = 1'b1;
    step();
    clear = 1'b0; key_ready = 1'b0;
    chk_idle("after_clear");
    step();
    chk("clear_no_done", 64'(done), 64'd0);
    run_seq(kk, 1'b0, 1'b0, -1);
    chk("clear_restart_k1", 64'(got[0]), 64'(ref_key(kk, 0)));

    // Asynchronous reset between edges mid-stream.
    kk = {$urandom, $urandom};
    user_key = kk; decrypt = 1'b1; start = 1'b1; key_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_async_valid", 64'(key_valid), 64'd1);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk_idle("async_reset");
    #1 n_rst = 1'b1;
    key_ready = 1'b0;
    @(negedge clk);
    step();
    chk_idle("async_reset_held");
    run_seq(kk, 1'b0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
